// File: rtl/fp_unpack_pkg.sv
// Shared FPU class-flag header: class one-hot bit indices, exponent constants,
// FSM state encoding and the IEEE-754 single-precision classifier.
package fp_unpack_pkg;

    localparam int CLASS_W            = 6;
    localparam int CLASS_BIT_ZERO      = 0;
    localparam int CLASS_BIT_SUBNORMAL = 1;
    localparam int CLASS_BIT_NORMAL    = 2;
    localparam int CLASS_BIT_INF       = 3;
    localparam int CLASS_BIT_SNAN      = 4;
    localparam int CLASS_BIT_QNAN      = 5;

    // Exponent constants, 11-bit two's complement
    localparam logic [10:0] EXP_ZERO    = 11'h781;  // -127
    localparam logic [10:0] EXP_SUBNORM = 11'h782;  // -126
    localparam logic [10:0] EXP_SPECIAL = 11'h080;  // 128
    localparam logic [10:0] EXP_BIAS    = 11'd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [CLASS_W-1:0] classify(input logic [31:0] fp);
        logic [7:0]         e;
        logic [22:0]        m;
        logic [CLASS_W-1:0] c;
        e = fp[30:23];
        m = fp[22:0];
        c = '0;
        if (e == 8'hFF) begin
            if (m == 23'd0)  c[CLASS_BIT_INF]  = 1'b1;
            else if (m[22])  c[CLASS_BIT_QNAN] = 1'b1;
            else             c[CLASS_BIT_SNAN] = 1'b1;
        end else if (e == 8'h00) begin
            if (m == 23'd0)  c[CLASS_BIT_ZERO]      = 1'b1;
            else             c[CLASS_BIT_SUBNORMAL] = 1'b1;
        end else begin
            c[CLASS_BIT_NORMAL] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_unpack_clz.sv
// Leading-zero count of a 23-bit mantissa; returns 23 for an all-zero input.
module fp_unpack_clz (
    input  logic [22:0] val_i,
    output logic [4:0]  lz_o
);

    // Scan from LSB upward so the last hit is the most significant set bit
    always_comb begin
        lz_o = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (val_i[i]) lz_o = 5'(22 - i);
        end
    end

endmodule

// File: rtl/fp_unpack.sv
// Unpacks an IEEE-754 single into class one-hot, unbiased exponent and 48-bit
// significand. Define FUNPACK_FAST_NORM_EN to normalize subnormals in one cycle.
module fp_unpack
    import fp_unpack_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  fp_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [31:0]  fp_o,
    output logic [10:0]  exp_o,
    output logic [47:0]  sig_o,
    output logic [5:0]   class_o
);

    // Handshake: a transfer happens on a rising clock edge where valid and
    // ready are both high; results hold steady while out_valid_o waits on ready.
    state_e      state_q, state_d;
    logic [31:0] fp_q, fp_d;
    logic [10:0] exp_q, exp_d;
    logic [47:0] sig_q, sig_d;
    logic [5:0]  class_q, class_d;
    logic [5:0]  cls_w;

    assign cls_w = classify(fp_i);

`ifdef FUNPACK_FAST_NORM_EN
    logic [4:0] lz_w;

    fp_unpack_clz u_clz (
        .val_i (fp_i[22:0]),
        .lz_o  (lz_w)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            fp_q    <= '0;
            exp_q   <= '0;
            sig_q   <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            fp_q    <= fp_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            class_q <= class_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fp_d    = fp_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        class_d = class_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    fp_d    = fp_i;
                    class_d = cls_w;
                    state_d = ST_DONE;
                    if (cls_w[CLASS_BIT_SUBNORMAL]) begin
`ifdef FUNPACK_FAST_NORM_EN
                        sig_d = {1'b0, fp_i[22:0], 24'b0} << (lz_w + 5'd1);
                        exp_d = EXP_ZERO - {6'b0, lz_w};
`else
                        sig_d   = {1'b0, fp_i[22:0], 24'b0};
                        exp_d   = EXP_SUBNORM;
                        state_d = ST_NORM;
`endif
                    end else if (cls_w[CLASS_BIT_ZERO]) begin
                        sig_d = '0;
                        exp_d = EXP_ZERO;
                    end else if (cls_w[CLASS_BIT_NORMAL]) begin
                        sig_d = {1'b1, fp_i[22:0], 24'b0};
                        exp_d = {3'b0, fp_i[30:23]} - EXP_BIAS;
                    end else begin
                        // INF and both NaNs share one packing; INF has mant=0
                        sig_d = {1'b1, fp_i[22:0], 24'b0};
                        exp_d = EXP_SPECIAL;
                    end
                end
            end
            ST_NORM: begin
                sig_d = {sig_q[46:0], 1'b0};
                exp_d = exp_q - 11'd1;
                if (sig_d[47]) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign fp_o        = fp_q;
    assign exp_o       = exp_q;
    assign sig_o       = sig_q;
    assign class_o     = class_q;

endmodule

// File: doc/fp_unpack.md
FP_UNPACK -- requirements
Module: fp_unpack

Interface
REQ-001 The module SHALL have port clk_i, input, width 1, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_i, input, width 1, the asynchronous active-high reset.
REQ-003 The module SHALL have port in_valid_i, input, width 1, meaning an operand is offered.
REQ-004 The module SHALL have port in_ready_o, output, width 1, meaning the unit can accept an operand.
REQ-005 The module SHALL have port fp_i, input, width 32, the raw IEEE-754 single-precision operand.
REQ-006 The module SHALL have port out_valid_o, output, width 1, meaning unpacked results are valid.
REQ-007 The module SHALL have port out_ready_i, input, width 1, meaning the consumer accepts the results.
REQ-008 The module SHALL have port fp_o, output, width 32, the raw operand passed through unchanged.
REQ-009 The module SHALL have port exp_o, output, width 11, the signed unbiased exponent.
REQ-010 The module SHALL have port sig_o, output, width 48, the significand with the hidden one at bit 47.
REQ-011 The module SHALL have port class_o, output, width 6, the class one-hot, indexed by the shared CLASS_BIT_* constants.

Function
REQ-012 Input handshake SHALL be a transfer when in_valid_i and in_ready_o are both high; in_ready_o SHALL be high only in state IDLE.
REQ-013 Output handshake SHALL be a transfer when out_valid_o and out_ready_i are both high; fp_o, exp_o, sig_o and class_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-014 The FSM SHALL have the states IDLE, NORM and DONE: IDLE->DONE on accept of a non-subnormal; IDLE->NORM on accept of a subnormal; NORM->DONE when sig bit 47 is set; DONE->IDLE on output transfer.
REQ-015 out_valid_o SHALL equal (state==DONE).
REQ-016 Class QNAN (exp 0xFF, mantissa bit22=1) SHALL give exp_o=128 and sig_o={1'b1, mant, 24'b0}.
REQ-017 Class SNAN (exp 0xFF, mantissa bit22=0, mantissa nonzero) SHALL give the same exp_o/sig_o packing as REQ-016.
REQ-018 Class INF (exp 0xFF, mantissa 0) SHALL give exp_o=128 and sig_o={1'b1, 47'b0}.
REQ-019 Class ZERO (exp 0, mantissa 0) SHALL give exp_o=-127 and sig_o=0, with the sign carried in fp_o only.
REQ-020 Class NORMAL SHALL give exp_o=e-127 and sig_o={1'b1, mant[22:0], 24'b0}, with a latency of 1 cycle from accept to out_valid_o.
REQ-021 Class SUBNORMAL SHALL load sig={1'b0, mant, 24'b0} and exp=-126 on accept; each NORM cycle SHALL shift sig left by 1 and decrement exp by 1.
REQ-022 NORM SHALL last lz+1 cycles, where lz is the leading-zero count of the 23-bit mantissa (0..22), giving a total latency of lz+2 cycles.
REQ-023 Subnormal results SHALL have a final exp in the range -127..-149 and class_o SUBNORMAL.
REQ-024 class_o SHALL be exactly one-hot for every input.
REQ-025 in_valid_i SHALL be ignored outside IDLE, so that back-to-back accepts occur at most once per DONE->IDLE pass.

Reset
REQ-026 When rst_i is asserted at any time, the FSM SHALL enter IDLE immediately, any in-flight normalization SHALL be abandoned, and all outputs SHALL reset to zero.
REQ-027 Outputs SHALL reset as follows: out_valid_o=0, in_ready_o=1 once released, fp_o=0, exp_o=0, sig_o=0, class_o=0.

Configuration
REQ-028 The unit SHALL support the macro FUNPACK_FAST_NORM_EN; when defined, subnormals SHALL normalize in the accept cycle using CLZ (shift lz+1, exp=-127-lz), NORM SHALL be unused, and all classes SHALL have a latency of 1.
REQ-029 When FUNPACK_FAST_NORM_EN is undefined, the iterative NORM behaviour of REQ-021..REQ-023 SHALL apply; results SHALL be bit-identical in both builds.

Structure
REQ-030 The CLASS_BIT_* indices, the exponent constants (-127, -126, 128) and the state encodings SHALL reside in the shared FPU class-flag header.
REQ-031 The fast build SHALL instantiate the existing CLZ sub-module; no other sub-modules SHALL be used.

Verification
REQ-032 A bench SHALL drive 0x3F800000 -> after 1 cycle: exp_o=0, sig_o=0x800000000000, class NORMAL.
REQ-033 A bench SHALL drive 0x00400000 -> iterative latency 2: exp_o=-127, sig_o=0x800000000000, class SUBNORMAL.
REQ-034 A bench SHALL drive 0x00000001 -> iterative latency 24, fast latency 1: exp_o=-149, sig_o=0x800000000000.
REQ-035 A bench SHALL drive 0x80000000, 0x7F800000, 0x7FC00000 and 0x7F800001 -> classes ZERO/INF/QNAN/SNAN with exp_o of -127/128/128/128 respectively.
REQ-036 A bench SHALL hold out_ready_i low for 5 cycles with an output pending -> outputs stable, in_ready_o=0, and a new in_valid_i ignored.
REQ-037 A bench SHALL assert rst_i during cycle 10 of a 0x00000001 normalization -> out_valid_o=0 immediately, and the next operand SHALL be processed correctly.
